// File: rtl/deconcat_stream.sv
// rtl/deconcat_stream.sv - splits {feature, context2} words into two independently drained FIFO streams
// Optional feature: define DECONCAT_CNT_EN to add the 16-bit accepted-word counter and word_cnt port.

module deconcat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_pop;

  // valid gates the pop, so an empty FIFO can never be read
  assign w_pop   = o_valid && i_ready;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == LP_DEPTH);

  // storage is left unreset; its content is don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // pointer and occupancy bookkeeping; push+pop together leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module deconcat_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   feat_data,
  output logic               feat_valid,
  input  logic               feat_ready,
  output logic [WIDTH-1:0]   ctx_data,
  output logic               ctx_valid,
`ifdef DECONCAT_CNT_EN
  output logic [15:0]        word_cnt,
`endif
  input  logic               ctx_ready
);
  logic w_feat_full;
  logic w_ctx_full;
  logic w_push;

  // accept only when both FIFOs have room so the two streams stay index-aligned;
  // depends on registered counts only, never on the consumer readies
  assign in_ready = !w_feat_full && !w_ctx_full;
  assign w_push   = in_valid && in_ready;

  deconcat_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_feat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (in_data[2*WIDTH-1:WIDTH]),
    .i_ready (feat_ready),
    .o_rdata (feat_data),
    .o_valid (feat_valid),
    .o_full  (w_feat_full)
  );

  deconcat_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ctx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (in_data[WIDTH-1:0]),
    .i_ready (ctx_ready),
    .o_rdata (ctx_data),
    .o_valid (ctx_valid),
    .o_full  (w_ctx_full)
  );

`ifdef DECONCAT_CNT_EN
  logic [15:0] r_word_cnt;

  // free-running count of accepted words, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_push) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif
endmodule

// File: tb/tb_deconcat_stream.sv
// tb/tb_deconcat_stream.sv - scoreboard bench for deconcat_stream

module tb_deconcat_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  feat_data;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [7:0]  ctx_data;
  logic        ctx_valid;
  logic        ctx_ready = 1'b0;
`ifdef DECONCAT_CNT_EN
  logic [15:0] word_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] feat_q[$];
  logic [7:0] ctx_q[$];

  deconcat_stream #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .feat_data  (feat_data),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .ctx_data   (ctx_data),
    .ctx_valid  (ctx_valid),
`ifdef DECONCAT_CNT_EN
    .word_cnt   (word_cnt),
`endif
    .ctx_ready  (ctx_ready)
  );

  always #5 clk = ~clk;

  // scoreboard: inputs change at posedge+1, so mid-cycle samples see settled handshakes
  always @(negedge clk) begin
    if (rst_n) begin
      if (feat_valid && feat_ready) begin
        checks++;
        if (feat_q.size() == 0) begin
          failures++;
          $display("FAIL feat_pop_unexpected got=%h expected=none", feat_data);
        end else begin
          logic [7:0] e;
          e = feat_q.pop_front();
          if (feat_data !== e) begin
            failures++;
            $display("FAIL feat_data got=%h expected=%h", feat_data, e);
          end
        end
      end
      if (ctx_valid && ctx_ready) begin
        checks++;
        if (ctx_q.size() == 0) begin
          failures++;
          $display("FAIL ctx_pop_unexpected got=%h expected=none", ctx_data);
        end else begin
          logic [7:0] e;
          e = ctx_q.pop_front();
          if (ctx_data !== e) begin
            failures++;
            $display("FAIL ctx_data got=%h expected=%h", ctx_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        feat_q.push_back(in_data[15:8]);
        ctx_q.push_back(in_data[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || feat_valid !== 1'b0 || ctx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b fv=%b cv=%b expected rdy=1 fv=0 cv=0", in_ready, feat_valid, ctx_valid);
    end
`ifdef DECONCAT_CNT_EN
    checks++;
    if (word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_word_cnt got=%h expected=0000", word_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    feat_ready = 1'b1;
    ctx_ready  = 1'b1;
    in_data    = 16'hAACC;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (feat_valid !== 1'b1 || ctx_valid !== 1'b1 || feat_data !== 8'hAA || ctx_data !== 8'hCC) begin
      failures++;
      $display("FAIL single_word got fv=%b cv=%b f=%h c=%h expected fv=1 cv=1 f=aa c=cc", feat_valid, ctx_valid, feat_data, ctx_data);
    end
    tick();
    checks++;
    if (feat_valid !== 1'b0 || ctx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_word_drain got fv=%b cv=%b expected fv=0 cv=0", feat_valid, ctx_valid);
    end
  endtask

  task automatic test_fill_stall();
    logic [15:0] words [4];
    words[0] = 16'h0FF0; words[1] = 16'hFF00; words[2] = 16'h1234; words[3] = 16'h5678;
    feat_ready = 1'b0;
    ctx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_in_ready word=%0d got=%b expected=1", i, in_ready);
      end
      in_data  = words[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got=%b expected=0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (ctx_valid !== 1'b0 || feat_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_skew got cv=%b fv=%b expected cv=0 fv=1", ctx_valid, feat_valid);
    end
    feat_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_before_pop got=%b expected=0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_after_pop got=%b expected=1", in_ready);
    end
    tick(); tick(); tick();
    checks++;
    if (feat_valid !== 1'b0 || feat_q.size() != 0 || ctx_q.size() != 0) begin
      failures++;
      $display("FAIL fill_drain got fv=%b fq=%0d cq=%0d expected fv=0 fq=0 cq=0", feat_valid, feat_q.size(), ctx_q.size());
    end
  endtask

  task automatic test_full_push_pop();
    feat_ready = 1'b0;
    ctx_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = 16'hA050 + 16'(i) * 16'h0101;
      in_valid = 1'b1;
      tick();
    end
    in_data = 16'hBEEF;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_both got=%b expected=0", in_ready);
    end
    feat_ready = 1'b1;
    ctx_ready  = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || feat_data !== 8'hA1 || ctx_data !== 8'h51) begin
      failures++;
      $display("FAIL full_pop_no_push got rdy=%b f=%h c=%h expected rdy=1 f=a1 c=51", in_ready, feat_data, ctx_data);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && (feat_valid || ctx_valid); i++) tick();
    checks++;
    if (feat_valid !== 1'b0 || ctx_valid !== 1'b0 || feat_q.size() != 0 || ctx_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain got fv=%b cv=%b fq=%0d cq=%0d expected all 0", feat_valid, ctx_valid, feat_q.size(), ctx_q.size());
    end
  endtask

  task automatic test_streaming();
    int idx = 0;
    int cyc = 0;
    logic acc;
    while (idx < 100 && cyc < 3000) begin
      in_data    = 16'(idx);
      in_valid   = 1'b1;
      feat_ready = 1'($urandom_range(0, 1));
      ctx_ready  = 1'($urandom_range(0, 1));
      acc = in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    while ((feat_valid || ctx_valid) && cyc < 3000) begin
      feat_ready = 1'($urandom_range(0, 1));
      ctx_ready  = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    checks++;
    if (idx != 100 || feat_q.size() != 0 || ctx_q.size() != 0 || feat_valid !== 1'b0 || ctx_valid !== 1'b0) begin
      failures++;
      $display("FAIL streaming got sent=%0d fq=%0d cq=%0d fv=%b cv=%b expected sent=100 all drained", idx, feat_q.size(), ctx_q.size(), feat_valid, ctx_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    feat_ready = 1'b0;
    ctx_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = 16'h3000 + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (feat_valid !== 1'b1 || ctx_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_buffered got fv=%b cv=%b expected fv=1 cv=1", feat_valid, ctx_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (feat_valid !== 1'b0 || ctx_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got fv=%b cv=%b rdy=%b expected fv=0 cv=0 rdy=1", feat_valid, ctx_valid, in_ready);
    end
    feat_q.delete();
    ctx_q.delete();
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (feat_valid !== 1'b0 || ctx_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after_release got fv=%b cv=%b expected fv=0 cv=0", feat_valid, ctx_valid);
    end
    test_single_word();
  endtask

`ifdef DECONCAT_CNT_EN
  task automatic test_counter_wrap();
    test_reset();
    feat_ready = 1'b1;
    ctx_ready  = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL counter_wrap got=%h expected=0001", word_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_fill_stall();
    test_full_push_pop();
    test_streaming();
    test_reset_mid_stream();
`ifdef DECONCAT_CNT_EN
    test_counter_wrap();
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
